// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

  // Sequencer FSM states: stretch reset, release stages one by one, idle when finished.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } rst_seq_state_t;

  // Largest of three values, used to size the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES rising clk edges.
module reset_sync_chain #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst_in,
  output logic rst_sync
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift a zero in from the bottom; the top flop is the synchronised reset.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b0};
  end

  // Chain flops: forced to all ones by rst_in, otherwise shift.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= {STAGES{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronises rst_in release, stretches it, then releases
// rst_out[0..NUM_OUT-1] in order with spacing, ready handshake and timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int USE_READY   = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               sw_rst_req,
  input  logic [NUM_OUT-1:0] stage_ready,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               seq_done,
  output logic               timeout_err
);

  localparam int CNT_W     = $clog2(max3(HOLD_CYCLES, STEP_CYCLES, TIMEOUT) + 1);
  localparam int STAGE_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0]   CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_OUT - 1);

  logic                rst_sync;
  rst_seq_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [STAGE_W-1:0]  stage_q, stage_d, stage_nxt;
  logic [NUM_OUT-1:0]  rst_out_q, rst_out_d;
  logic                seq_done_q, seq_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                step_ok, to_hit;

  reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_in   (rst_in),
    .rst_sync (rst_sync)
  );

  // Next-state logic: soft restart first, then HOLD stretch / STEP release / DONE idle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_d       = stage_q;
    rst_out_d     = rst_out_q;
    seq_done_d    = seq_done_q;
    timeout_err_d = timeout_err_q;
    // Saturate so a long wait with no timeout cannot wrap below the spacing threshold.
    cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});
    stage_nxt = stage_q + {{(STAGE_W-1){1'b0}}, 1'b1};
    step_ok   = (cnt_q >= STEP_LAST) && ((USE_READY == 0) || stage_ready[stage_q]);
    to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    if (sw_rst_req) begin
      // Sync chain is untouched, so HOLD starts counting on the very next edge.
      state_d    = HOLD;
      cnt_d      = {CNT_W{1'b0}};
      stage_d    = {STAGE_W{1'b0}};
      rst_out_d  = {NUM_OUT{1'b1}};
      seq_done_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (rst_sync) begin
            cnt_d = {CNT_W{1'b0}};
          end else if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = {CNT_W{1'b0}};
            stage_d      = {STAGE_W{1'b0}};
            state_d      = STEP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STEP: begin
          cnt_d = cnt_inc;
          if (step_ok || to_hit) begin
            // A ready stage wins over a coincident timeout.
            if (!step_ok) begin
              timeout_err_d = 1'b1;
            end else begin
              timeout_err_d = timeout_err_q;
            end
            if (stage_q < LAST_STAGE) begin
              rst_out_d[stage_nxt] = 1'b0;
              stage_d              = stage_nxt;
              cnt_d                = {CNT_W{1'b0}};
            end else begin
              seq_done_d = 1'b1;
              state_d    = DONE;
            end
          end else begin
            stage_d = stage_q;
          end
        end
        DONE: begin
          seq_done_d = 1'b1;
          rst_out_d  = {NUM_OUT{1'b0}};
        end
        default: begin
          state_d    = HOLD;
          cnt_d      = {CNT_W{1'b0}};
          stage_d    = {STAGE_W{1'b0}};
          rst_out_d  = {NUM_OUT{1'b1}};
          seq_done_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, all forced to their reset values by rst_in.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= HOLD;
      cnt_q         <= {CNT_W{1'b0}};
      stage_q       <= {STAGE_W{1'b0}};
      rst_out_q     <= {NUM_OUT{1'b1}};
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      rst_out_q     <= rst_out_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign seq_done    = seq_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: three sequencer instances (default, short timeout, ready ignored)
// share clk/rst_in/sw_rst_req; expected output transitions are queued with their edge.
module tb_reset_sequencer;

  typedef struct {
    int         id;
    int         cyc;
    logic [2:0] ro;
    logic       sd;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rdy [3];
  logic [2:0] ro [3];
  logic       sd [3];
  logic       te [3];

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_ro [3];
  logic       prev_sd [3];
  exp_t sb_q[$];

  reset_sequencer #(.TIMEOUT(1024)) u_def (
    .clk(clk), .rst_in(rst_in), .sw_rst_req(sw_rst_req), .stage_ready(rdy[0]),
    .rst_out(ro[0]), .seq_done(sd[0]), .timeout_err(te[0])
  );
  reset_sequencer #(.TIMEOUT(32)) u_to (
    .clk(clk), .rst_in(rst_in), .sw_rst_req(sw_rst_req), .stage_ready(rdy[1]),
    .rst_out(ro[1]), .seq_done(sd[1]), .timeout_err(te[1])
  );
  reset_sequencer #(.USE_READY(0)) u_nr (
    .clk(clk), .rst_in(rst_in), .sw_rst_req(sw_rst_req), .stage_ready(rdy[2]),
    .rst_out(ro[2]), .seq_done(sd[2]), .timeout_err(te[2])
  );

  always #5 if (clk_en) clk = ~clk;

  // Edge counter: after rising edge N, cyc reads N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input int c, input logic [2:0] r, input logic d);
    exp_t e;
    e.id = id; e.cyc = c; e.ro = r; e.sd = d;
    sb_q.push_back(e);
  endtask

  // Full release order for one instance: three stage releases then seq_done.
  task automatic push_seq(input int id, input int c0, input int c1, input int c2, input int cd);
    push_exp(id, c0, 3'b110, 1'b0);
    push_exp(id, c1, 3'b100, 1'b0);
    push_exp(id, c2, 3'b000, 1'b0);
    push_exp(id, cd, 3'b000, 1'b1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic pulse_sw(output int c);
    c = cyc;
    sw_rst_req = 1'b1;
    wait_cyc(c + 1);
    sw_rst_req = 1'b0;
  endtask

  // Monitor: every output change must match the oldest queued expectation for that instance.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mon_en && ((ro[d] !== prev_ro[d]) || (sd[d] !== prev_sd[d]))) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
          if (sb_q[i].id == d) begin
            idx = i;
            break;
          end
        end
        if (idx < 0) begin
          check_val($sformatf("d%0d_unexpected_change", d), {28'd0, ro[d], sd[d]},
                    {28'd0, prev_ro[d], prev_sd[d]});
        end else begin
          check_val($sformatf("d%0d_edge", d), cyc, sb_q[idx].cyc);
          check_val($sformatf("d%0d_rst_out", d), {29'd0, ro[d]}, {29'd0, sb_q[idx].ro});
          check_val($sformatf("d%0d_seq_done", d), {31'd0, sd[d]}, {31'd0, sb_q[idx].sd});
          sb_q.delete(idx);
        end
      end
      prev_ro[d] = ro[d];
      prev_sd[d] = sd[d];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int r;
    rdy[0] = 3'b111; rdy[1] = 3'b111; rdy[2] = 3'b000;

    // Asynchronous assertion with the clock stopped.
    #5 rst_in = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("d%0d_async_rst_out", d), {29'd0, ro[d]}, 32'h7);
      check_val($sformatf("d%0d_async_done", d), {31'd0, sd[d]}, 32'h0);
      check_val($sformatf("d%0d_async_terr", d), {31'd0, te[d]}, 32'h0);
    end
    clk_en = 1'b1;
    wait_cyc(3);
    check_val("held_rst_out", {29'd0, ro[0]}, 32'h7);

    // Phase 1: default release schedule.
    c = cyc;
    rst_in = 1'b0;
    mon_en = 1'b1;
    for (int d = 0; d < 3; d++) push_seq(d, c + 20, c + 28, c + 36, c + 44);
    wait_cyc(c + 50);
    for (int d = 0; d < 3; d++) check_val($sformatf("d%0d_p1_terr", d), {31'd0, te[d]}, 32'h0);

    // Phase 2: software restart from DONE, no resync delay.
    for (int d = 0; d < 3; d++) begin
      push_exp(d, cyc + 1, 3'b111, 1'b0);
      push_seq(d, cyc + 17, cyc + 25, cyc + 33, cyc + 41);
    end
    pulse_sw(c);
    wait_cyc(c + 45);

    // Phase 3: late ready on u_def, stuck ready[1] on u_to, ready ignored on u_nr.
    rdy[0] = 3'b000; rdy[1] = 3'b101; rdy[2] = 3'b000;
    r = cyc + 17;
    for (int d = 0; d < 3; d++) begin
      push_exp(d, cyc + 1, 3'b111, 1'b0);
      push_exp(d, r, 3'b110, 1'b0);
    end
    push_exp(0, r + 41, 3'b100, 1'b0);
    push_exp(0, r + 49, 3'b000, 1'b0);
    push_exp(0, r + 57, 3'b000, 1'b1);
    push_exp(1, r + 8, 3'b100, 1'b0);
    push_exp(1, r + 40, 3'b000, 1'b0);
    push_exp(1, r + 48, 3'b000, 1'b1);
    push_exp(2, r + 8, 3'b100, 1'b0);
    push_exp(2, r + 16, 3'b000, 1'b0);
    push_exp(2, r + 24, 3'b000, 1'b1);
    pulse_sw(c);
    wait_cyc(r + 39);
    check_val("to_terr_before", {31'd0, te[1]}, 32'h0);
    wait_cyc(r + 40);
    rdy[0] = 3'b111;
    wait_cyc(r + 60);
    check_val("def_terr", {31'd0, te[0]}, 32'h0);
    check_val("to_terr", {31'd0, te[1]}, 32'h1);
    check_val("nr_terr", {31'd0, te[2]}, 32'h0);

    // Phase 4: timeout_err survives a software restart.
    rdy[1] = 3'b111;
    for (int d = 0; d < 3; d++) begin
      push_exp(d, cyc + 1, 3'b111, 1'b0);
      push_seq(d, cyc + 17, cyc + 25, cyc + 33, cyc + 41);
    end
    pulse_sw(c);
    wait_cyc(c + 2);
    check_val("to_terr_sticky", {31'd0, te[1]}, 32'h1);
    wait_cyc(c + 45);
    check_val("to_terr_sticky_end", {31'd0, te[1]}, 32'h1);

    // Phase 5: rst_in asserted in STEP with rst_out=100, then a full fresh sequence.
    for (int d = 0; d < 3; d++) begin
      push_exp(d, cyc + 1, 3'b111, 1'b0);
      push_exp(d, cyc + 17, 3'b110, 1'b0);
      push_exp(d, cyc + 25, 3'b100, 1'b0);
    end
    pulse_sw(c);
    wait_cyc(c + 28);
    mon_en = 1'b0;
    rst_in = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("d%0d_mid_rst_out", d), {29'd0, ro[d]}, 32'h7);
      check_val($sformatf("d%0d_mid_done", d), {31'd0, sd[d]}, 32'h0);
      check_val($sformatf("d%0d_mid_terr", d), {31'd0, te[d]}, 32'h0);
    end
    wait_cyc(c + 31);
    c = cyc;
    rst_in = 1'b0;
    mon_en = 1'b1;
    for (int d = 0; d < 3; d++) push_seq(d, c + 20, c + 28, c + 36, c + 44);
    wait_cyc(c + 50);
    for (int d = 0; d < 3; d++) check_val($sformatf("d%0d_final_done", d), {31'd0, sd[d]}, 32'h1);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
